// File: rtl/uart_transmitter_byte.sv
// uart_transmitter_byte
//   UART byte transmitter. Serialises one DATA_BITS word per frame on tx:
//   a start bit, the data LSB first, then STOP_BITS stop bits. Bit timing
//   comes from a shared 16x baud strobe. A one-word holding register behind
//   a valid/ready handshake lets the next word wait while a frame is on the
//   line, so consecutive frames go out back to back.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   baud_tick  one-clk strobe at OVERSAMPLE x baud
//   data_in    word to send, taken when in_valid & in_ready
//   in_valid   producer offers data_in
//   in_ready   holding register empty
//   tx         serial output, idle high, registered
//   busy       high from start-bit entry to end of the last stop bit
//   tx_done    one-clk pulse when the last stop bit completes
//
// state   | meaning
// S_IDLE  | line idle (tx=1), waiting for a held word and a tick
// S_START | start bit (tx=0) for one bit period
// S_DATA  | data bits, LSB first, from the shift register
// S_STOP  | stop bit(s) (tx=1); may chain straight into S_START

module uart_transmitter_byte #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [CNT_W-1:0]       r_tick_cnt;
   logic [2:0]             r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   w_shift_next;
   logic [DATA_BITS-1:0]   r_hold;
   logic                   r_hold_full;
   logic                   r_tx;
   logic                   r_busy;
   logic                   r_done;
   logic                   w_bit_end;
   logic                   w_load;
   logic                   w_done;
   logic                   w_tx_next;

   assign w_bit_end = (r_state != S_IDLE) && baud_tick && (r_tick_cnt == TICK_LAST);

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Starting only on a tick keeps every bit exactly OVERSAMPLE ticks long.
            if (r_hold_full && baud_tick) begin
               w_load       = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_bit_end && (r_bit_cnt == DATA_LAST)) w_state_next = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end && (r_bit_cnt == STOP_LAST)) begin
               w_done = 1'b1;
               // The bit end is itself a tick, so a held word starts with no idle gap.
               if (r_hold_full) begin
                  w_load       = 1'b1;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_shift_next = r_shift;
      if (w_load) begin
         w_shift_next = r_hold;
      end else if ((r_state == S_DATA) && w_bit_end) begin
         w_shift_next = r_shift >> 1;
      end
      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         r_busy  <= (w_state_next != S_IDLE);
         r_done  <= w_done;

         if ((w_state_next != r_state) || w_bit_end) begin
            r_tick_cnt <= '0;
         end else if ((r_state != S_IDLE) && baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end

         if (w_state_next != r_state) begin
            r_bit_cnt <= '0;
         end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end

         // Write and drain are exclusive: a write needs the register empty,
         // a drain needs it full.
         if (in_valid && !r_hold_full) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   assign in_ready = !r_hold_full;
   assign tx       = r_tx;
   assign busy     = r_busy;
   assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_transmitter_byte.sv
// tb_uart_transmitter_byte
//   Directed bench for uart_transmitter_byte. One 8N1 instance carries most
//   tests; a second instance with two stop bits shares clk, rst and the tick.
//   A bench-side receiver samples tx at the middle of each bit and decodes frames.

module tb_uart_transmitter_byte;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic [7:0] data_in, data_in2;
   logic       in_valid, in_valid2;
   logic       in_ready, tx, busy, tx_done;
   logic       in_ready2, tx2, busy2, tx_done2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_transmitter_byte dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
      .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   uart_transmitter_byte #(.STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .data_in(data_in2), .in_valid(in_valid2), .in_ready(in_ready2),
      .tx(tx2), .busy(busy2), .tx_done(tx_done2)
   );

   // Tick every 4th clk, changed just after posedge so it is stable at negedge.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 baud_tick = 1'b1;
         @(posedge clk);
         #1 baud_tick = 1'b0;
      end
   end

   // Bench receiver for the 8N1 instance.
   int         ft = 0;
   int         done_cnt = 0;
   int         unstable = 0;
   int         last_len = 0;
   logic [9:0] fb = '0;
   logic [9:0] last_fb = '0;
   logic       prev_tx = 1'b1;
   logic [7:0] rx_q[$];
   logic       done_tx_q[$];

   always @(negedge clk) begin
      if (rst) begin
         ft = 0;
      end else begin
         if (tx_done) begin
            last_len = ft;
            last_fb  = fb;
            rx_q.push_back(fb[8:1]);
            done_tx_q.push_back(tx);
            done_cnt++;
            ft = 0;
         end
         if (busy && baud_tick) begin
            ft++;
            if ((ft % 16) != 1 && tx !== prev_tx) unstable++;
            prev_tx = tx;
            if ((ft % 16) == 8 && ft < 160) fb[ft/16] = tx;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk); #1;
      while (!in_ready && n < 4000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("send_ready", in_ready, 1);
      data_in  = b;
      in_valid = 1'b1;
      @(negedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int n = 0;
      while (done_cnt < target && n < 8000) begin
         @(negedge clk); #1;
         n++;
      end
      chk(tag, (done_cnt >= target), 1);
   endtask

   initial begin
      int base;
      int n;
      int k;
      int t;
      int ones;
      logic [7:0]  v;
      logic [7:0]  exp_q[$];
      logic [10:0] fb2;

      rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
      data_in = 8'h00; data_in2 = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_done", tx_done, 0);
      @(negedge clk); #2 rst = 1'b0;

      // 1: single 0xA5 frame, latency and shape
      send_byte(8'hA5);
      chk("t1_ready_low", in_ready, 0);
      n = 0;
      while (!baud_tick && n < 10) begin
         @(negedge clk); #1;
         n++;
      end
      chk("t1_pre_tx", tx, 1);
      @(negedge clk); #1;
      chk("t1_lat_tx", tx, 0);
      chk("t1_lat_busy", busy, 1);
      chk("t1_ready_back", in_ready, 1);
      wait_done(1, "t1_timeout");
      chk("t1_done_pulse", tx_done, 1);
      chk("t1_bits", last_fb, {1'b1, 8'hA5, 1'b0});
      chk("t1_len", last_len, 160);
      @(negedge clk); #1;
      chk("t1_done_clr", tx_done, 0);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_tx", tx, 1);
      chk("t1_cnt", done_cnt, 1);

      // 2: back-to-back 0x00 / 0xFF
      rx_q.delete(); done_tx_q.delete();
      base = done_cnt;
      send_byte(8'h00);
      send_byte(8'hFF);
      wait_done(base + 2, "t2_timeout");
      chk("t2_count", rx_q.size(), 2);
      chk("t2_b0", rx_q[0], 8'h00);
      chk("t2_b1", rx_q[1], 8'hFF);
      chk("t2_no_gap", done_tx_q[0], 0);
      chk("t2_len", last_len, 160);

      // 3: in_valid held with data changing every clk
      repeat (700) @(negedge clk);
      rx_q.delete();
      base = done_cnt;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk); #1;
         v = 8'(i * 37 + 11);
         data_in  = v;
         in_valid = 1'b1;
         if (in_ready) exp_q.push_back(v);
      end
      @(negedge clk); #1;
      in_valid = 1'b0;
      k = exp_q.size();
      chk("t3_enough", (k >= 3), 1);
      wait_done(base + k, "t3_timeout");
      repeat (800) @(negedge clk);
      #1;
      chk("t3_count", rx_q.size(), k);
      for (int i = 0; i < k; i++) chk("t3_byte", rx_q[i], exp_q[i]);

      // 4: reset during data bit 3 with a word held
      base = done_cnt;
      send_byte(8'h3C);
      send_byte(8'h77);
      n = 0;
      while (ft != 70 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("t4_reach_bit3", ft, 70);
      chk("t4_held", in_ready, 0);
      #1 rst = 1'b1;
      #1;
      chk("t4_rst_tx", tx, 1);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_ready", in_ready, 1);
      chk("t4_rst_done", tx_done, 0);
      @(negedge clk); #2 rst = 1'b0;
      repeat (1500) @(negedge clk);
      #1;
      chk("t4_discard", done_cnt, base);
      chk("t4_idle", busy, 0);
      rx_q.delete();
      send_byte(8'h96);
      wait_done(base + 1, "t4_timeout");
      chk("t4_byte", rx_q[0], 8'h96);
      chk("t4_bits", last_fb, {1'b1, 8'h96, 1'b0});
      chk("t4_len", last_len, 160);

      // 5: receiver loopback
      rx_q.delete();
      base = done_cnt;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h55);
      send_byte(8'h3C);
      wait_done(base + 4, "t5_timeout");
      chk("t5_count", rx_q.size(), 4);
      chk("t5_b0", rx_q[0], 8'h00);
      chk("t5_b1", rx_q[1], 8'hFF);
      chk("t5_b2", rx_q[2], 8'h55);
      chk("t5_b3", rx_q[3], 8'h3C);
      chk("t5_stable", unstable, 0);

      // 6: two stop bits, 0x81
      @(negedge clk); #1;
      data_in2  = 8'h81;
      in_valid2 = 1'b1;
      @(negedge clk); #1;
      in_valid2 = 1'b0;
      n = 0; t = 0; ones = 0; fb2 = '0;
      while (n < 3000) begin
         @(negedge clk); #1;
         n++;
         if (tx_done2) break;
         if (busy2 && baud_tick) begin
            t++;
            if (tx2) ones++;
            else ones = 0;
            if ((t % 16) == 8 && t < 176) fb2[t/16] = tx2;
         end
      end
      chk("t6_done", tx_done2, 1);
      chk("t6_len", t, 176);
      chk("t6_tail_high", ones, 48);
      chk("t6_bits", fb2, {2'b11, 8'h81, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
